sm_controller: RTL and testbench
================================

# sm_controller

Command-driven controller that sequences the four PIO state machines from the host side. It owns their enable mask, synchronous restarts, clock-divider restarts, instruction-memory writes and forced-instruction (EXEC) injection. It sits between the host register interface and the state-machine array, driving each machine's `en`, `reset`, divider restart, `imm` and injected `instr`. Commands are processed one at a time over a valid/ready handshake.

## Interface
Parameters:
- `NUM_SM`, 4: number of state machines controlled.
- `RST_CYCLES`, 2: cycles `sm_reset` is held per RESTART (1..15).
- `EXEC_TIMEOUT`, 255: maximum cycles to wait for an EXEC to issue (1..255).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  opcode: 0 NOP, 1 ENABLE, 2 DISABLE, 3 RESTART, 4 DIV_RESTART, 5 EXEC, 6 IMEM_WRITE, 7 illegal.
- `cmd_mask`  in  NUM_SM  target machines.
- `cmd_data`  in  21  [15:0] instruction word; [20:16] memory address.
- `exec_tick`  in  NUM_SM  per-machine `en & penable` strobe.
- `sm_en`  out  NUM_SM  per-machine enable.
- `sm_reset`  out  NUM_SM  per-machine synchronous reset.
- `div_restart`  out  NUM_SM  per-machine divider-phase restart pulse.
- `imm`  out  NUM_SM  forced-instruction select.
- `exec_instr`  out  16  forced instruction word.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  5  write address.
- `imem_data`  out  16  write data.
- `busy`  out  1  a multi-cycle command is in progress.
- `done`  out  1  one-cycle pulse when a command completes successfully.
- `err`  out  1  one-cycle pulse when a command is rejected or times out.

## Operation
- States: IDLE, RESTART, EXEC_WAIT. `cmd_ready` = (state == IDLE) and not `reset`.
- A command is accepted when `cmd_valid & cmd_ready`. All outputs are registered.
- ENABLE: `sm_en |= mask`.
- DISABLE: `sm_en &= ~mask`.
- NOP: `done` only.
- DIV_RESTART: `div_restart = mask` for one cycle; `done` in the same cycle.
- IMEM_WRITE: `imem_we` for one cycle, with `imem_addr = cmd_data[20:16]` and `imem_data = cmd_data[15:0]`; `done` in the same cycle.
- RESTART:
  - Enter RESTART and latch the mask.
  - Assert `sm_reset[mask]` for RST_CYCLES cycles.
  - While in RESTART, force `sm_en` low for masked machines; the stored enable bits are not modified.
  - On exit, `sm_reset` clears, enables are restored from the stored bits, `done` pulses, and the controller returns to IDLE.
- EXEC:
  - Target is the lowest set bit of the mask.
  - Rejected with `err` (no state change) if the mask is zero or the target's stored enable is 0.
  - Otherwise latch `exec_instr = cmd_data[15:0]`, set `imm[target]`, and enter EXEC_WAIT.
  - In EXEC_WAIT, a sampled `exec_tick[target]` clears `imm`, pulses `done`, and returns to IDLE.
  - If EXEC_TIMEOUT cycles elapse without a tick, clear `imm`, pulse `err`, and return to IDLE.
- Opcode 7: `err` pulse, accepted, no other effect.
- `busy` = state != IDLE.
- Reset values: `sm_en`, `sm_reset`, `div_restart`, `imm` = 0; `exec_instr`, `imem_*` = 0; `busy`, `done`, `err` = 0; state = IDLE.
- Reset wins over every simultaneous event. Reset mid-RESTART or mid-EXEC aborts the command with no `done` or `err`.

## Timing
- Command accepted at cycle N.
- ENABLE, DISABLE, DIV_RESTART, IMEM_WRITE and NOP take effect at N+1 with `done` at N+1. Back-to-back acceptance is allowed every cycle.
- RESTART: `sm_reset` high for cycles N+1 .. N+RST_CYCLES. At N+RST_CYCLES+1: `sm_reset` low, enables restored, `done` high, `cmd_ready` high.
- EXEC: `imm` high from N+1. If `exec_tick[target]` is sampled high in cycle M, then at M+1 `imm` is low, `done` is high and `cmd_ready` is high. With no tick, `err` is at N+1+EXEC_TIMEOUT.
- A tick present in cycle N itself is ignored; the instruction must be presented before it counts.
- Rejected EXEC: `err` at N+1, and `cmd_ready` stays high.

## Configuration
- `SM_CONTROLLER_EXEC_EN` defined: EXEC is supported as above.
- `SM_CONTROLLER_EXEC_EN` undefined:
  - Opcode 5 is treated as illegal (`err` at N+1).
  - EXEC_WAIT, the timeout counter and the `exec_instr` register are removed.
  - `imm` and `exec_instr` are tied to 0.

## Test plan
- Reset, then ENABLE with mask 4'b0101 → `sm_en` = 0101 at N+1 and `done` pulse. Then DISABLE with mask 0001 → `sm_en` = 0100.
- RESTART with mask 0110, `sm_en` = 0111, RST_CYCLES = 2 → `sm_reset` = 0110 for exactly 2 cycles and `sm_en` = 0001 meanwhile. At N+3: `sm_en` = 0111, `done`, `cmd_ready` high. `cmd_valid` held during RESTART is not accepted.
- EXEC 0xE001 to mask 0010 (SM1 enabled), `exec_tick[1]` at N+4 → `imm` = 0010 with `exec_instr` = 0xE001 for N+1..N+4, cleared and `done` at N+5.
- EXEC to a disabled SM, and EXEC with mask 0 → `err` at N+1, `imm` stays 0. EXEC with no tick and EXEC_TIMEOUT = 8 → `err` at N+9, `imm` cleared.
- IMEM_WRITE with data 0x15A5C3 → `imem_we` at N+1 with addr 0x15 and data 0xA5C3. DIV_RESTART with mask 1111 → single-cycle `div_restart` = 1111.
- Reset asserted at N+2 of an EXEC and of a RESTART → all outputs 0 next cycle, no `done` or `err`, `cmd_ready` high.

Source files
------------

// File: rtl/sm_controller_if.sv
// ----------------------------------------------------------------------------
// sm_controller_if
// Host command channel of sm_controller (valid/ready handshake).
//   cmd_valid  host -> ctrl  command present
//   cmd_ready  ctrl -> host  controller can accept a command
//   cmd_op     host -> ctrl  3-bit opcode
//   cmd_mask   host -> ctrl  target state machines
//   cmd_data   host -> ctrl  [15:0] instruction word, [20:16] memory address
// Modports: master = host side, slave = controller side.
// ----------------------------------------------------------------------------
interface sm_controller_if #(
  parameter int NUM_SM = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [NUM_SM-1:0] cmd_mask;
  logic [20:0]       cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_mask, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_data, output cmd_ready);
endinterface

// File: rtl/sm_controller.sv
// ----------------------------------------------------------------------------
// sm_controller
// Sequences the PIO state machines from the host side: enable mask,
// timed synchronous restarts, divider restarts, instruction-memory writes
// and forced-instruction (EXEC) injection. One command at a time.
//
// Optional feature macro: SM_CONTROLLER_EXEC_EN
//   defined   -> EXEC supported (EXEC_WAIT state, timeout counter, exec_instr)
//   undefined -> opcode 5 is rejected like opcode 7; imm/exec_instr tied to 0
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd               command channel (sm_controller_if.slave)
//   exec_tick         per-machine en&penable strobe (EXEC completion)
//   sm_en, sm_reset   per-machine enable / synchronous reset
//   div_restart       per-machine divider-phase restart pulse
//   imm, exec_instr   forced-instruction select and word
//   imem_we/addr/data instruction-memory write port
//   busy, done, err   status (done/err are one-cycle pulses)
// ----------------------------------------------------------------------------
module sm_controller #(
  parameter int NUM_SM       = 4,
  parameter int RST_CYCLES   = 2,
  parameter int EXEC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  sm_controller_if.slave    cmd,
  input  logic [NUM_SM-1:0] exec_tick,
  output logic [NUM_SM-1:0] sm_en,
  output logic [NUM_SM-1:0] sm_reset,
  output logic [NUM_SM-1:0] div_restart,
  output logic [NUM_SM-1:0] imm,
  output logic [15:0]       exec_instr,
  output logic              imem_we,
  output logic [4:0]        imem_addr,
  output logic [15:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESTART = 2'd1, ST_EXEC_WAIT = 2'd2} state_t;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_ENABLE  = 3'd1;
  localparam logic [2:0] OP_DISABLE = 3'd2;
  localparam logic [2:0] OP_RESTART = 3'd3;
  localparam logic [2:0] OP_DIV     = 3'd4;
  localparam logic [2:0] OP_EXEC    = 3'd5;
  localparam logic [2:0] OP_IMEM    = 3'd6;

`ifdef SM_CONTROLLER_EXEC_EN
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_TIMEOUT - 1);
`else
  localparam int CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

  state_t            state_r, state_s;
  logic [NUM_SM-1:0] en_r, en_s;              // stored enables (untouched by RESTART)
  logic [CNT_W-1:0]  cnt_r, cnt_s;            // cycles remaining in RESTART / EXEC_WAIT
  logic [NUM_SM-1:0] sm_en_r, sm_en_s;
  logic [NUM_SM-1:0] sm_reset_r, sm_reset_s;
  logic [NUM_SM-1:0] div_restart_r, div_restart_s;
  logic              imem_we_r, imem_we_s;
  logic [4:0]        imem_addr_r, imem_addr_s;
  logic [15:0]       imem_data_r, imem_data_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              accept_s;
`ifdef SM_CONTROLLER_EXEC_EN
  logic [NUM_SM-1:0] imm_r, imm_s;            // one-hot EXEC target while waiting
  logic [15:0]       exec_instr_r, exec_instr_s;
  logic [NUM_SM-1:0] target_s;

  // Isolate the lowest set bit of a mask (EXEC target selection).
  function automatic logic [NUM_SM-1:0] lowest_bit(input logic [NUM_SM-1:0] m);
    return m & (~m + NUM_SM'(1));
  endfunction

  assign target_s = lowest_bit(cmd.cmd_mask);
`endif

  assign cmd.cmd_ready = (state_r == ST_IDLE) && !reset;
  assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    state_s       = state_r;
    en_s          = en_r;
    cnt_s         = cnt_r;
    sm_en_s       = sm_en_r;
    sm_reset_s    = sm_reset_r;
    div_restart_s = '0;
    imem_we_s     = 1'b0;
    imem_addr_s   = imem_addr_r;
    imem_data_s   = imem_data_r;
    done_s        = 1'b0;
    err_s         = 1'b0;
`ifdef SM_CONTROLLER_EXEC_EN
    imm_s         = imm_r;
    exec_instr_s  = exec_instr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd.cmd_op)
            OP_NOP: done_s = 1'b1;
            OP_ENABLE: begin
              en_s    = en_r | cmd.cmd_mask;
              sm_en_s = en_r | cmd.cmd_mask;
              done_s  = 1'b1;
            end
            OP_DISABLE: begin
              en_s    = en_r & ~cmd.cmd_mask;
              sm_en_s = en_r & ~cmd.cmd_mask;
              done_s  = 1'b1;
            end
            OP_RESTART: begin
              // Masked machines are held disabled while in reset; en_r keeps
              // the bits to restore on exit, so no separate mask latch is needed.
              sm_reset_s = cmd.cmd_mask;
              sm_en_s    = en_r & ~cmd.cmd_mask;
              cnt_s      = RST_LOAD;
              state_s    = ST_RESTART;
            end
            OP_DIV: begin
              div_restart_s = cmd.cmd_mask;
              done_s        = 1'b1;
            end
            OP_IMEM: begin
              imem_we_s   = 1'b1;
              imem_addr_s = cmd.cmd_data[20:16];
              imem_data_s = cmd.cmd_data[15:0];
              done_s      = 1'b1;
            end
`ifdef SM_CONTROLLER_EXEC_EN
            OP_EXEC: begin
              // An empty mask yields an empty target, which is also rejected.
              if ((target_s & en_r) == '0) begin
                err_s = 1'b1;
              end else begin
                imm_s        = target_s;
                exec_instr_s = cmd.cmd_data[15:0];
                cnt_s        = EXEC_LOAD;
                state_s      = ST_EXEC_WAIT;
              end
            end
`endif
            default: err_s = 1'b1;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RESTART: begin
        if (cnt_r == '0) begin
          sm_reset_s = '0;
          sm_en_s    = en_r;
          done_s     = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
`ifdef SM_CONTROLLER_EXEC_EN
      ST_EXEC_WAIT: begin
        // A tick in the final timeout cycle still counts as success.
        if ((exec_tick & imm_r) != '0) begin
          imm_s   = '0;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (cnt_r == '0) begin
          imm_s   = '0;
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      en_r          <= '0;
      cnt_r         <= '0;
      sm_en_r       <= '0;
      sm_reset_r    <= '0;
      div_restart_r <= '0;
      imem_we_r     <= 1'b0;
      imem_addr_r   <= 5'd0;
      imem_data_r   <= 16'h0000;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
`ifdef SM_CONTROLLER_EXEC_EN
      imm_r         <= '0;
      exec_instr_r  <= 16'h0000;
`endif
    end else begin
      state_r       <= state_s;
      en_r          <= en_s;
      cnt_r         <= cnt_s;
      sm_en_r       <= sm_en_s;
      sm_reset_r    <= sm_reset_s;
      div_restart_r <= div_restart_s;
      imem_we_r     <= imem_we_s;
      imem_addr_r   <= imem_addr_s;
      imem_data_r   <= imem_data_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      err_r         <= err_s;
`ifdef SM_CONTROLLER_EXEC_EN
      imm_r         <= imm_s;
      exec_instr_r  <= exec_instr_s;
`endif
    end
  end

  assign sm_en       = sm_en_r;
  assign sm_reset    = sm_reset_r;
  assign div_restart = div_restart_r;
  assign imem_we     = imem_we_r;
  assign imem_addr   = imem_addr_r;
  assign imem_data   = imem_data_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
`ifdef SM_CONTROLLER_EXEC_EN
  assign imm         = imm_r;
  assign exec_instr  = exec_instr_r;
`else
  logic unused_tick_s;
  assign unused_tick_s = ^exec_tick;
  assign imm           = '0;
  assign exec_instr    = 16'h0000;
`endif
endmodule

// File: tb/tb_sm_controller.sv
// ----------------------------------------------------------------------------
// tb_sm_controller: directed test-plan steps followed by random commands,
// all checked against a command-level model of the controller (stored
// enable mask plus per-command cycle expectations).
// ----------------------------------------------------------------------------
module tb_sm_controller;
  localparam int NUM_SM       = 4;
  localparam int RST_CYCLES   = 2;
  localparam int EXEC_TIMEOUT = 8;
`ifdef SM_CONTROLLER_EXEC_EN
  localparam bit EXEC_ON = 1'b1;
`else
  localparam bit EXEC_ON = 1'b0;
`endif
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_ENABLE  = 3'd1;
  localparam logic [2:0] OP_DISABLE = 3'd2;
  localparam logic [2:0] OP_RESTART = 3'd3;
  localparam logic [2:0] OP_DIV     = 3'd4;
  localparam logic [2:0] OP_EXEC    = 3'd5;
  localparam logic [2:0] OP_IMEM    = 3'd6;
  localparam logic [2:0] OP_ILL     = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  exec_tick;
  logic [3:0]  sm_en, sm_reset, div_restart, imm;
  logic [15:0] exec_instr, imem_data;
  logic [4:0]  imem_addr;
  logic        imem_we, busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [3:0] m_en;   // model: stored enable mask

  sm_controller_if #(.NUM_SM(NUM_SM)) cmd_bus ();

  sm_controller #(.NUM_SM(NUM_SM), .RST_CYCLES(RST_CYCLES), .EXEC_TIMEOUT(EXEC_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd(cmd_bus), .exec_tick(exec_tick),
    .sm_en(sm_en), .sm_reset(sm_reset), .div_restart(div_restart), .imm(imm),
    .exec_instr(exec_instr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_en, input logic [3:0] e_rst,
                            input logic [3:0] e_div, input logic [3:0] e_imm, input logic e_done,
                            input logic e_err, input logic e_busy, input logic e_ready);
    chk({tag, ".sm_en"}, sm_en, e_en);
    chk({tag, ".sm_reset"}, sm_reset, e_rst);
    chk({tag, ".div_restart"}, div_restart, e_div);
    chk({tag, ".imm"}, imm, e_imm);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".err"}, err, e_err);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".cmd_ready"}, cmd_bus.cmd_ready, e_ready);
  endtask

  // Issue one command and check every following cycle until it completes.
  // noise: exec_tick during the accept cycle and on non-target bits while waiting.
  // tick_k: wait cycle (1-based) in which the EXEC target ticks, 0 = never.
  // hold: keep presenting ENABLE 1111 while the command is in progress.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] mask, input logic [20:0] data,
                        input logic [3:0] noise, input int tick_k, input bit hold);
    logic [3:0] tgt;
    bit         ok, fin, hit;
    tgt = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) tgt = 4'b0001 << i;
    end
    chk("pre.cmd_ready", cmd_bus.cmd_ready, 1'b1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_mask  = mask;
    cmd_bus.cmd_data  = data;
    exec_tick         = noise;
    cyc();
    exec_tick = 4'b0000;
    if (hold) begin
      cmd_bus.cmd_op   = OP_ENABLE;
      cmd_bus.cmd_mask = 4'b1111;
    end else begin
      cmd_bus.cmd_valid = 1'b0;
    end
    case (op)
      OP_RESTART: begin
        for (int k = 1; k <= RST_CYCLES; k++) begin
          check_outs("restart.hold", m_en & ~mask, mask, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
          cyc();
        end
        check_outs("restart.end", m_en, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      OP_EXEC: begin
        ok = EXEC_ON && ((m_en & tgt) != 4'b0000);
        if (!ok) begin
          check_outs("exec.reject", m_en, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        end else begin
          fin = 1'b0;
          hit = 1'b0;
          for (int k = 1; k <= EXEC_TIMEOUT && !fin; k++) begin
            check_outs("exec.wait", m_en, 4'b0000, 4'b0000, tgt, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("exec.instr", exec_instr, data[15:0]);
            exec_tick = (noise & ~tgt) | ((k == tick_k) ? tgt : 4'b0000);
            if (k == tick_k) begin
              fin = 1'b1;
              hit = 1'b1;
            end
            cyc();
            exec_tick = 4'b0000;
          end
          check_outs("exec.end", m_en, 4'b0000, 4'b0000, 4'b0000, hit, !hit, 1'b0, 1'b1);
        end
      end
      default: begin
        case (op)
          OP_ENABLE:  m_en = m_en | mask;
          OP_DISABLE: m_en = m_en & ~mask;
          default:    m_en = m_en;
        endcase
        check_outs("simple", m_en, 4'b0000, (op == OP_DIV) ? mask : 4'b0000, 4'b0000,
                   op != OP_ILL, op == OP_ILL, 1'b0, 1'b1);
        chk("simple.imem_we", imem_we, op == OP_IMEM);
        if (op == OP_IMEM) begin
          chk("imem.addr", imem_addr, data[20:16]);
          chk("imem.data", imem_data, data[15:0]);
        end
      end
    endcase
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Start a multi-cycle command, then assert reset in its N+2 cycle.
  task automatic abort_test(input logic [2:0] op, input logic [3:0] mask);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_mask  = mask;
    cmd_bus.cmd_data  = 21'h00ABCD;
    cyc();
    cmd_bus.cmd_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    check_outs("abort.reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.exec_instr", exec_instr, 16'h0000);
    reset = 1'b0;
    #1;
    chk("abort.ready", cmd_bus.cmd_ready, 1'b1);
    m_en = 4'b0000;
    cyc();
    check_outs("abort.after", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [3:0]  r_mask, r_noise;
    logic [20:0] r_data;
    reset             = 1'b1;
    exec_tick         = 4'b0000;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 3'd0;
    cmd_bus.cmd_mask  = 4'b0000;
    cmd_bus.cmd_data  = 21'd0;
    m_en              = 4'b0000;
    cyc();
    cyc();
    check_outs("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.imem_we", imem_we, 1'b0);
    chk("reset.imem_addr", imem_addr, 5'd0);
    chk("reset.imem_data", imem_data, 16'h0000);
    chk("reset.exec_instr", exec_instr, 16'h0000);
    reset = 1'b0;
    #1;
    chk("reset.release_ready", cmd_bus.cmd_ready, 1'b1);

    // Directed test-plan steps
    do_cmd(OP_ENABLE,  4'b0101, 21'd0, 4'b0000, 0, 1'b0);
    do_cmd(OP_DISABLE, 4'b0001, 21'd0, 4'b0000, 0, 1'b0);
    do_cmd(OP_ENABLE,  4'b0011, 21'd0, 4'b0000, 0, 1'b0);
    do_cmd(OP_RESTART, 4'b0110, 21'd0, 4'b0000, 0, 1'b1);
    do_cmd(OP_EXEC,    4'b0010, 21'h00E001, 4'b1111, 4, 1'b1);
    do_cmd(OP_DISABLE, 4'b0010, 21'd0, 4'b0000, 0, 1'b0);
    do_cmd(OP_EXEC,    4'b0010, 21'h001234, 4'b0000, 1, 1'b0);
    do_cmd(OP_EXEC,    4'b0000, 21'h001234, 4'b0000, 1, 1'b0);
    do_cmd(OP_EXEC,    4'b1100, 21'h00BEEF, 4'b1011, 0, 1'b0);
    do_cmd(OP_EXEC,    4'b0100, 21'h004321, 4'b0000, EXEC_TIMEOUT, 1'b0);
    do_cmd(OP_IMEM,    4'b0000, 21'h15A5C3, 4'b0000, 0, 1'b0);
    do_cmd(OP_DIV,     4'b1111, 21'd0, 4'b0000, 0, 1'b0);
    do_cmd(OP_NOP,     4'b1111, 21'd0, 4'b0000, 0, 1'b0);
    do_cmd(OP_ILL,     4'b1111, 21'd0, 4'b0000, 0, 1'b0);
    abort_test(OP_EXEC, 4'b0000);
    do_cmd(OP_ENABLE,  4'b1111, 21'd0, 4'b0000, 0, 1'b0);
    abort_test(OP_EXEC, 4'b1000);
    do_cmd(OP_ENABLE,  4'b1111, 21'd0, 4'b0000, 0, 1'b0);
    abort_test(OP_RESTART, 4'b0011);

    // Random command stream
    for (int n = 0; n < 80; n++) begin
      r_op    = 3'($urandom_range(0, 7));
      r_mask  = 4'($urandom);
      r_data  = 21'($urandom);
      r_noise = 4'($urandom);
      do_cmd(r_op, r_mask, r_data, r_noise, $urandom_range(0, EXEC_TIMEOUT + 2),
             ((r_op == OP_RESTART) || (r_op == OP_EXEC)) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
